adc_array_capture: RTL and testbench

ADC_ARRAY_CAPTURE -- requirements
Module: adc_array_capture

---
 rtl/adc_array_pkg.sv | 17 +
 rtl/adc_shift_lane.sv | 21 ++
 rtl/adc_array_capture.sv | 156 +++++++++++++++
 tb/tb_adc_array_capture.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_array_pkg.sv
// rtl/adc_array_pkg.sv - shared state encoding and timing helpers for the ADC array capture block
package adc_array_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2,
        LOAD    = 2'd3
    } state_t;

    // One capture spans CONVERT + SHIFT + LOAD, and IDLE must be revisited on counter value 0.
    function automatic int min_sample_period(input int conv_cycles, input int clk_div,
                                             input int sample_bits);
        return conv_cycles + 2 * clk_div * sample_bits + 2;
    endfunction

endpackage

// File: rtl/adc_shift_lane.sv
// rtl/adc_shift_lane.sv - one MSB-first serial-to-parallel lane with shift enable and clear
module adc_shift_lane #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             sdo,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data <= '0;
        end else if (shift) begin
            data <= (data << 1) | WIDTH'(sdo);
        end
    end

endmodule

// File: rtl/adc_array_capture.sv
// rtl/adc_array_capture.sv - shared CNV/SCLK capture of NUM_CH serial ADCs onto one stream word
// Optional overflow counter enabled by defining ADC_ARRAY_OVF_CNT_EN.
module adc_array_capture
    import adc_array_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int SAMPLE_BITS   = 16,
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 70,
    parameter int SAMPLE_PERIOD = 200,
    parameter int OVF_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_CH-1:0]             adc_sdo,
    output logic                          adc_cnv,
    output logic                          adc_sclk,
    output logic [NUM_CH*SAMPLE_BITS-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [OVF_WIDTH-1:0]          overflow_count,
    output logic                          busy
);

    localparam int PER_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;

    if (SAMPLE_PERIOD < min_sample_period(CONV_CYCLES, CLK_DIV, SAMPLE_BITS)) begin : g_bad_period
        $error("adc_array_capture: SAMPLE_PERIOD too short for one capture");
    end

    state_t                          state_q, state_d;
    logic [PER_W-1:0]                period_cnt;
    logic [CONV_W-1:0]               conv_cnt;
    logic [DIV_W-1:0]                div_cnt;
    logic [BIT_W-1:0]                bit_cnt;
    logic                            sclk_q;
    logic [NUM_CH*SAMPLE_BITS-1:0]   lane_data;

    logic start, conv_last, div_last, bit_last, shift_en, shift_done, load_ok;

    always_comb begin
        conv_last  = (conv_cnt == CONV_W'(CONV_CYCLES - 1));
        div_last   = (div_cnt == DIV_W'(CLK_DIV - 1));
        bit_last   = (bit_cnt == BIT_W'(SAMPLE_BITS - 1));
        start      = (state_q == IDLE) && enable && (period_cnt == '0);
        // Lanes sample on the edge that raises SCLK: last cycle of a low half-period.
        shift_en   = (state_q == SHIFT) && div_last && !sclk_q;
        shift_done = (state_q == SHIFT) && div_last && sclk_q && bit_last;
        load_ok    = !m_axis_tvalid || m_axis_tready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = CONVERT;
            CONVERT: if (conv_last)  state_d = SHIFT;
            SHIFT:   if (shift_done) state_d = LOAD;
            LOAD:                    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt    <= '0;
            conv_cnt      <= '0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            sclk_q        <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (!enable || period_cnt == PER_W'(SAMPLE_PERIOD - 1)) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 1'b1;
            end

            if (state_q == CONVERT && !conv_last) begin
                conv_cnt <= conv_cnt + 1'b1;
            end else begin
                conv_cnt <= '0;
            end

            if (state_q == SHIFT) begin
                if (div_last) begin
                    div_cnt <= '0;
                    sclk_q  <= ~sclk_q;
                    if (sclk_q) begin
                        bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
                bit_cnt <= '0;
                sclk_q  <= 1'b0;
            end

            // A pending word is never overwritten; a load in the handshake cycle keeps tvalid high.
            if (state_q == LOAD && load_ok) begin
                m_axis_tdata  <= lane_data;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        adc_shift_lane #(
            .WIDTH (SAMPLE_BITS)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clear (start),
            .shift (shift_en),
            .sdo   (adc_sdo[k]),
            .data  (lane_data[k*SAMPLE_BITS +: SAMPLE_BITS])
        );
    end

`ifdef ADC_ARRAY_OVF_CNT_EN
    logic [OVF_WIDTH-1:0] ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (state_q == LOAD && !load_ok && ovf_q != '1) begin
            ovf_q <= ovf_q + 1'b1;
        end
    end

    assign overflow_count = ovf_q;
`else
    assign overflow_count = '0;
`endif

    assign adc_cnv  = (state_q == CONVERT);
    assign adc_sclk = sclk_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_adc_array_capture.sv
// tb/tb_adc_array_capture.sv - directed self-checking bench for adc_array_capture
module tb_adc_array_capture;

    localparam int NUM_CH = 4;
    localparam int SB     = 16;
`ifdef ADC_ARRAY_OVF_CNT_EN
    localparam int EXP_OVF = 2;
`else
    localparam int EXP_OVF = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [NUM_CH-1:0] adc_sdo;
    logic              adc_cnv;
    logic              adc_sclk;
    logic [63:0]       m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic [15:0]       overflow_count;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] words [NUM_CH];
    logic [4:0]  bit_idx = '0;

    adc_array_capture #(
        .NUM_CH        (4),
        .SAMPLE_BITS   (16),
        .CLK_DIV       (2),
        .CONV_CYCLES   (70),
        .SAMPLE_PERIOD (200),
        .OVF_WIDTH     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .adc_sdo        (adc_sdo),
        .adc_cnv        (adc_cnv),
        .adc_sclk       (adc_sclk),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .overflow_count (overflow_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // ADC model: conversion start rewinds to the MSB, data advances on SCLK falling edges.
    always @(posedge adc_cnv) bit_idx <= '0;
    always @(negedge adc_sclk) if (bit_idx < 5'd16) bit_idx <= bit_idx + 5'd1;

    always_comb begin
        adc_sdo = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bit_idx < 5'd16) adc_sdo[k] = words[k][4'(5'd15 - bit_idx)];
        end
    end

    task automatic set_words(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        words[3] = w3;
    endtask

    task automatic wait_cnv_rise(output int n);
        n = -1;
        for (int i = 1; i <= 450; i++) begin
            @(negedge clk);
            if (adc_cnv) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_tvalid(output int n);
        n = -1;
        for (int i = 1; i <= 450; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        checks++; if ({adc_cnv, adc_sclk, busy} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got cnv/sclk/busy %b want 000", {adc_cnv, adc_sclk, busy}); end
        checks++; if (overflow_count !== 16'h0) begin errors++; $display("FAIL reset_ovf got %0d want 0", overflow_count); end
    endtask

    task automatic test_first_capture();
        int n, lat, width;
        set_words(16'h8000, 16'h0000, 16'hFFFF, 16'h1234);
        m_axis_tready = 1'b1;
        enable = 1'b1;
        wait_cnv_rise(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL first_cnv_start got %0d want 1", n); end
        lat = -1;
        width = 1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (adc_cnv) width++;
            if (m_axis_tvalid) begin
                lat = i;
                break;
            end
        end
        checks++; if (width !== 70) begin errors++; $display("FAIL cnv_width got %0d want 70", width); end
        checks++; if (lat !== 135) begin errors++; $display("FAIL first_latency got %0d want 135", lat); end
        checks++; if (m_axis_tdata !== 64'h1234_FFFF_0000_8000) begin errors++; $display("FAIL first_tdata got %h want 1234ffff00008000", m_axis_tdata); end
        @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL tvalid_one_cycle got %0b want 0", m_axis_tvalid); end
    endtask

    task automatic test_back_to_back();
        int n, highs, rises, first_rise, valids;
        logic prev;
        set_words(16'hA5A5, 16'h5A5A, 16'h0001, 16'hFFFE);
        wait_cnv_rise(n);
        checks++; if (n < 0) begin errors++; $display("FAIL b2b_cnv_timeout got %0d want >0", n); end
        prev = 1'b1;
        highs = 1;
        rises = 0;
        first_rise = -1;
        valids = 0;
        for (int i = 1; i <= 399; i++) begin
            @(negedge clk);
            if (adc_cnv) highs++;
            if (adc_cnv && !prev) begin
                rises++;
                if (first_rise < 0) first_rise = i;
            end
            if (m_axis_tvalid) valids++;
            prev = adc_cnv;
        end
        checks++; if (highs !== 140) begin errors++; $display("FAIL b2b_cnv_high got %0d want 140", highs); end
        checks++; if (first_rise !== 200 || rises !== 1) begin errors++; $display("FAIL b2b_period got %0d/%0d want 200/1", first_rise, rises); end
        checks++; if (valids !== 2) begin errors++; $display("FAIL b2b_valid_pulses got %0d want 2", valids); end
        checks++; if (m_axis_tdata !== 64'hFFFE_0001_5A5A_A5A5) begin errors++; $display("FAIL b2b_tdata got %h want fffe00015a5aa5a5", m_axis_tdata); end
        checks++; if (overflow_count !== 16'h0) begin errors++; $display("FAIL b2b_ovf got %0d want 0", overflow_count); end
    endtask

    task automatic test_backpressure();
        int n, bad_data, bad_valid;
        do_reset();
        set_words(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        m_axis_tready = 1'b0;
        enable = 1'b1;
        wait_tvalid(n);
        checks++; if (n !== 136) begin errors++; $display("FAIL bp_first_latency got %0d want 136", n); end
        set_words(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
        bad_data = 0;
        bad_valid = 0;
        for (int i = 0; i < 420; i++) begin
            @(negedge clk);
            if (m_axis_tdata !== 64'h4444_3333_2222_1111) bad_data++;
            if (m_axis_tvalid !== 1'b1) bad_valid++;
        end
        checks++; if (bad_data !== 0) begin errors++; $display("FAIL bp_tdata_hold got %0d changed cycles want 0", bad_data); end
        checks++; if (bad_valid !== 0) begin errors++; $display("FAIL bp_tvalid_hold got %0d low cycles want 0", bad_valid); end
        checks++; if (overflow_count !== 16'(EXP_OVF)) begin errors++; $display("FAIL bp_ovf got %0d want %0d", overflow_count, EXP_OVF); end
        m_axis_tready = 1'b1;
        @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_release got %0b want 0", m_axis_tvalid); end
    endtask

    task automatic test_enable_drop();
        int n, cnv_seen;
        do_reset();
        set_words(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
        m_axis_tready = 1'b1;
        enable = 1'b1;
        wait_cnv_rise(n);
        repeat (99) @(negedge clk);
        enable = 1'b0;
        wait_tvalid(n);
        checks++; if (n !== 36) begin errors++; $display("FAIL drop_latency got %0d want 36", n); end
        checks++; if (m_axis_tdata !== 64'hFF00_00FF_F0F0_0F0F) begin errors++; $display("FAIL drop_tdata got %h want ff0000fff0f00f0f", m_axis_tdata); end
        cnv_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (adc_cnv) cnv_seen++;
        end
        checks++; if (cnv_seen !== 0 || busy !== 1'b0) begin errors++; $display("FAIL drop_no_cnv got cnv=%0d busy=%0b want 0/0", cnv_seen, busy); end
        enable = 1'b1;
        @(negedge clk);
        checks++; if (adc_cnv !== 1'b1) begin errors++; $display("FAIL reenable_cnv got %0b want 1", adc_cnv); end
    endtask

    task automatic test_reset_mid_shift();
        int n;
        repeat (90) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_shift_busy got %0b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({adc_cnv, adc_sclk, m_axis_tvalid, busy} !== 4'b0000) begin errors++; $display("FAIL midrst_ctrl got %b want 0000", {adc_cnv, adc_sclk, m_axis_tvalid, busy}); end
        checks++; if (m_axis_tdata !== 64'h0 || overflow_count !== 16'h0) begin errors++; $display("FAIL midrst_data got %h/%0d want 0/0", m_axis_tdata, overflow_count); end
        rst = 1'b0;
        set_words(16'hCAFE, 16'hBEEF, 16'h0F0F, 16'h7001);
        wait_cnv_rise(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL midrst_restart got %0d want 1", n); end
        wait_tvalid(n);
        checks++; if (n !== 135) begin errors++; $display("FAIL midrst_latency got %0d want 135", n); end
        checks++; if (m_axis_tdata !== 64'h7001_0F0F_BEEF_CAFE) begin errors++; $display("FAIL midrst_tdata got %h want 70010f0fbeefcafe", m_axis_tdata); end
    endtask

    initial begin
        set_words(16'h0, 16'h0, 16'h0, 16'h0);
        test_reset();
        test_first_capture();
        test_back_to_back();
        test_backpressure();
        test_enable_drop();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
